leakage_sweep_ctrl: RTL

LEAKAGE_SWEEP_CTRL -- requirements
Module: leakage_sweep_ctrl

---
 rtl/leakage_pkg.sv | 18 +
 rtl/leakage_timer.sv | 35 +++
 rtl/leakage_sweep_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/leakage_pkg.sv
// Shared types and constants for the leakage sweep controller.
// Holds the FSM state encoding and table geometry.
package leakage_pkg;

  localparam int NB_VEC     = 4;
  localparam int MEAS_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    TRIG,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/leakage_timer.sv
// Loadable down-counter; zero flags the cycle in which
// the count arrives at (or sits at) zero.
module leakage_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign zero = (cnt_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/leakage_sweep_ctrl.sv
// Steps a two-input cell through 00,01,10,11, triggers a
// leakage measurement per vector and stores the magnitudes.
module leakage_sweep_ctrl
  import leakage_pkg::*;
#(
  parameter int SETTLE_CYCLES = 700,
  parameter int MEAS_CYCLES   = 700,
  parameter int MEAS_W        = MEAS_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [MEAS_W-1:0] measure_int,
  output logic                     din,
  output logic                     din2,
  output logic                     start_measure,
  output logic                     busy,
  output logic                     done,
  input  logic [1:0]               rd_idx,
  output logic [MEAS_W-1:0]        rd_data,
  output logic                     rd_valid
);

  localparam int TMAX =
    (SETTLE_CYCLES > MEAS_CYCLES) ? SETTLE_CYCLES : MEAS_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [MEAS_W-1:0] MIN_V =
    {1'b1, {(MEAS_W-1){1'b0}}};
  localparam logic [MEAS_W-1:0] MAX_V =
    {1'b0, {(MEAS_W-1){1'b1}}};

  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [NB_VEC-1:0] valid_q, valid_d;
  logic [NB_VEC-1:0][MEAS_W-1:0] tab_q, tab_d;
  logic din_q, din_d;
  logic din2_q, din2_d;
  logic sm_q, sm_d;

  logic          tmr_load;
  logic          tmr_dec;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic [MEAS_W-1:0] neg_val;

  assign tmr_load = (state_q == APPLY) || (state_q == TRIG);
  assign tmr_dec  = (state_q == SETTLE) || (state_q == WAIT);
  assign tmr_val  = (state_q == APPLY) ? TW'(SETTLE_CYCLES)
                                       : TW'(MEAS_CYCLES);

  leakage_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  // Most negative sample has no positive twin; clamp it.
  assign neg_val = (measure_int == MIN_V) ? MAX_V
                                          : ('0 - measure_int);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    tab_d   = tab_q;
    din_d   = din_q;
    din2_d  = din2_q;
    sm_d    = sm_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      din_d   = 1'b0;
      din2_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = APPLY;
            idx_d   = '0;
            valid_d = '0;
          end
        end
        APPLY: begin
          din_d   = idx_q[1];
          din2_d  = idx_q[0];
          state_d = SETTLE;
        end
        SETTLE: begin
          if (tmr_zero) state_d = TRIG;
        end
        TRIG: begin
          sm_d    = ~sm_q;
          state_d = WAIT;
        end
        WAIT: begin
          if (tmr_zero) state_d = CAPTURE;
        end
        CAPTURE: begin
          tab_d[idx_q]   = neg_val;
          valid_d[idx_q] = 1'b1;
          if (idx_q == 2'd3) begin
            state_d = DONE;
            din_d   = 1'b0;
            din2_d  = 1'b0;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = APPLY;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= '0;
      tab_q   <= '0;
      din_q   <= 1'b0;
      din2_q  <= 1'b0;
      sm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tab_q   <= tab_d;
      din_q   <= din_d;
      din2_q  <= din2_d;
      sm_q    <= sm_d;
    end
  end

  assign din           = din_q;
  assign din2          = din2_q;
  assign start_measure = sm_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign rd_data       = tab_q[rd_idx];
  assign rd_valid      = valid_q[rd_idx];

endmodule
